crossing_gate_sequencer: RTL

- Level-crossing controller that shares one road gate (barrier motor plus warning lamps) between two railway tracks.
- Tracks per-track train occupancy from approach and exit detectors.
- Sequences warn, lower, hold, clear-delay and raise.
- Supervises the barrier motor with end-stop switches and a timeout, and latches a fail-safe fault.
- Sits between the track-sensor front end and the lamp/motor drivers; replaces the single-switch crossing FSM for multi-track crossings.

---
 rtl/crossing_pkg.sv | 29 ++
 rtl/track_occupancy_counter.sv | 33 +++
 rtl/crossing_gate_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/crossing_pkg.sv
// Shared definitions for the two-track level-crossing gate sequencer:
// state encoding, default timing and the Moore output bundle.
package crossing_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_WARN   = 3'd1;
  localparam state_t ST_LOWER  = 3'd2;
  localparam state_t ST_CLOSED = 3'd3;
  localparam state_t ST_HOLD   = 3'd4;
  localparam state_t ST_RAISE  = 3'd5;
  localparam state_t ST_FAULT  = 3'd6;

  localparam int DEF_WARN_CYCLES   = 10;
  localparam int DEF_CLEAR_CYCLES  = 4;
  localparam int DEF_MOTOR_TIMEOUT = 16;
  localparam int DEF_FLASH_DIV     = 2;
  localparam int DEF_TMR_W         = 5;

  typedef struct packed {
    logic warn;
    logic motorDown;
    logic motorUp;
    logic closed;
    logic fault;
  } gate_out_t;

endpackage

// File: rtl/track_occupancy_counter.sv
// Per-track train occupancy: 2-bit saturating up/down counter fed by
// approach and exit pulses, with a nonzero flag.
module track_occupancy_counter (
  input  logic clk_i,
  input  logic reset_i,
  input  logic approach_i,
  input  logic exit_i,
  output logic occupied_o
);

  logic [1:0] count_q, count_d;

  // Simultaneous approach and exit cancel; exit at zero is a stray pulse.
  always_comb begin
    count_d = count_q;
    if (approach_i && !exit_i && count_q != 2'd3) begin
      count_d = count_q + 2'd1;
    end else if (exit_i && !approach_i && count_q != 2'd0) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign occupied_o = |count_q;

endmodule

// File: rtl/crossing_gate_sequencer.sv
// Two-track level-crossing controller: sequences warning lamps and one
// barrier motor, supervises end-stops and latches a fail-safe fault.
module crossing_gate_sequencer
  import crossing_pkg::*;
#(
  parameter int WARN_CYCLES   = DEF_WARN_CYCLES,
  parameter int CLEAR_CYCLES  = DEF_CLEAR_CYCLES,
  parameter int MOTOR_TIMEOUT = DEF_MOTOR_TIMEOUT,
  parameter int FLASH_DIV     = DEF_FLASH_DIV,
  parameter int TMR_W         = DEF_TMR_W
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] approach_i,
  input  logic [1:0] exit_det_i,
  input  logic       gate_down_sw_i,
  input  logic       gate_up_sw_i,
  input  logic       fault_clr_i,
  output logic       warn_led_o,
  output logic       flash_o,
  output logic       motor_down_o,
  output logic       motor_up_o,
  output logic       gate_closed_o,
  output logic       fault_o,
  output logic [1:0] occupied_o
);

  localparam logic [TMR_W-1:0] WARN_LAST  = TMR_W'(WARN_CYCLES - 1);
  localparam logic [TMR_W-1:0] CLEAR_LAST = TMR_W'(CLEAR_CYCLES - 1);
  localparam logic [TMR_W-1:0] MOTOR_LAST = TMR_W'(MOTOR_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] FLASH_LAST = TMR_W'(FLASH_DIV - 1);

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [TMR_W-1:0] flashCnt_q, flashCnt_d;
  logic             flash_q, flash_d;
  logic [1:0]       occ;
  logic             anyOcc, anyApproach, downOk, upOk, stopConflict;
  gate_out_t        gateOut;

  for (genvar t = 0; t < 2; t++) begin : gTrack
    track_occupancy_counter uCounter (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .approach_i (approach_i[t]),
      .exit_i     (exit_det_i[t]),
      .occupied_o (occ[t])
    );
  end

  assign anyOcc       = |occ;
  assign anyApproach  = |approach_i;
  assign downOk       = gate_down_sw_i && !gate_up_sw_i;
  assign upOk         = gate_up_sw_i && !gate_down_sw_i;
  assign stopConflict = gate_down_sw_i && gate_up_sw_i;

  // A new approach during RAISE re-closes straight away without re-warning;
  // unknown encodings fall into FAULT so the barrier never runs unsupervised.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (anyApproach || anyOcc) state_d = ST_WARN;
      end
      ST_WARN: begin
        if (timer_q == WARN_LAST) state_d = ST_LOWER;
      end
      ST_LOWER: begin
        if (downOk) state_d = ST_CLOSED;
        else if (stopConflict || timer_q == MOTOR_LAST) state_d = ST_FAULT;
      end
      ST_CLOSED: begin
        if (!anyOcc) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (anyApproach) state_d = ST_CLOSED;
        else if (timer_q == CLEAR_LAST) state_d = ST_RAISE;
      end
      ST_RAISE: begin
        if (anyApproach) state_d = ST_LOWER;
        else if (upOk) state_d = ST_IDLE;
        else if (stopConflict || timer_q == MOTOR_LAST) state_d = ST_FAULT;
      end
      ST_FAULT: begin
        if (fault_clr_i) state_d = ST_LOWER;
      end
      default: state_d = ST_FAULT;
    endcase
  end

  always_comb begin
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q == '1) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TMR_W'(1);
    end
  end

  // The divider only runs on cycles where the lamps are already lit, and is
  // cleared on the edge that returns to IDLE so flash is never seen unlit.
  always_comb begin
    flashCnt_d = flashCnt_q;
    flash_d    = flash_q;
    if (state_d == ST_IDLE) begin
      flashCnt_d = '0;
      flash_d    = 1'b0;
    end else if (state_q != ST_IDLE) begin
      if (flashCnt_q == FLASH_LAST) begin
        flashCnt_d = '0;
        flash_d    = ~flash_q;
      end else begin
        flashCnt_d = flashCnt_q + TMR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      flashCnt_q <= '0;
      flash_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      flashCnt_q <= flashCnt_d;
      flash_q    <= flash_d;
    end
  end

  always_comb begin
    gateOut = '0;
    unique case (state_q)
      ST_IDLE:   gateOut = '0;
      ST_WARN:   gateOut.warn = 1'b1;
      ST_LOWER:  begin gateOut.warn = 1'b1; gateOut.motorDown = 1'b1; end
      ST_CLOSED: begin gateOut.warn = 1'b1; gateOut.closed = 1'b1; end
      ST_HOLD:   begin gateOut.warn = 1'b1; gateOut.closed = 1'b1; end
      ST_RAISE:  begin gateOut.warn = 1'b1; gateOut.motorUp = 1'b1; end
      default:   begin gateOut.warn = 1'b1; gateOut.fault = 1'b1; end
    endcase
  end

  assign warn_led_o    = gateOut.warn;
  assign flash_o       = flash_q;
  assign motor_down_o  = gateOut.motorDown;
  assign motor_up_o    = gateOut.motorUp;
  assign gate_closed_o = gateOut.closed;
  assign fault_o       = gateOut.fault;
  assign occupied_o    = occ;

endmodule
